cim_weight_loader: RTL and testbench

Write-side initiator for the two-bank CIM array. Accepts a valid/ready stream of weight words, serialises each 8-row bank load into the array's D / WA / cima write port, and tracks per-bank "loaded" flags so that compute can ping-pong between banks. Sits between the weight DMA/stream source and the CIM array write port.

---
 rtl/cim_pkg.sv | 24 ++
 rtl/cim_row_onehot.sv | 44 ++++
 rtl/cim_weight_loader.sv | 191 +++++++++++++++++++
 tb/tb_cim_weight_loader.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cim_pkg.sv
// ---------------------------------------------------------------------------
// cim_pkg
// Shared definitions for the CIM weight-loader slice:
//   CIM_DATA_W / CIM_ROWS  : array write-port geometry (D width, WA width)
//   CIM_TIMEOUT            : default stall limit for the optional timeout
//   loader_state_e         : loader FSM states
//   BANK0 / BANK1          : bank index constants
// ---------------------------------------------------------------------------
package cim_pkg;

    localparam int CIM_DATA_W  = 24;
    localparam int CIM_ROWS    = 8;
    localparam int CIM_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_e;

    localparam logic BANK0 = 1'b0;
    localparam logic BANK1 = 1'b1;

endpackage

// File: rtl/cim_row_onehot.sv
// ---------------------------------------------------------------------------
// cim_row_onehot
// Row counter for one bank load with a one-hot decode of the current row.
//   clk, rst   : clock, asynchronous active-high reset
//   clr_i      : force the counter back to row 0
//   inc_i      : advance to the next row (wraps after ROWS-1)
//   onehot_o   : one-hot decode of the current row
//   last_o     : current row is ROWS-1
// ---------------------------------------------------------------------------
module cim_row_onehot #(
    parameter int ROWS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            inc_i,
    output logic [ROWS-1:0] onehot_o,
    output logic            last_o
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [RW-1:0] row_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
        end else if (clr_i) begin
            row_q <= '0;
        end else if (inc_i) begin
            row_q <= last_o ? '0 : row_q + RW'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_onehot
            assign onehot_o[gi] = (row_q == RW'(gi));
        end
    endgenerate

    assign last_o = (row_q == RW'(ROWS - 1));

endmodule

// File: rtl/cim_weight_loader.sv
// ---------------------------------------------------------------------------
// cim_weight_loader
// Write-side initiator for the two-bank CIM array. Takes a valid/ready
// stream of weight words and writes each 8-row bank load into the array
// D / WA / cima port, tracking per-bank "loaded" flags for ping-pong compute.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start_i         : request one bank load (1-cycle pulse)
//   bank_sel_i      : target bank for start_i
//   s_valid_i/s_data_i/s_ready_o : weight word stream
//   release_i[1:0]  : per-bank pulse, compute is finished with the bank
//   d_o, wa_o, cima_o : registered array write port (wa_o one-hot, 0 = idle;
//                       cima_o 1 = bank 0, 0 = bank 1)
//   busy_o          : load in progress (LOAD or DONE)
//   done_o          : 1-cycle pulse, load completed
//   bank_full_o     : bank holds a complete, unreleased weight set
//   start_err_o     : 1-cycle pulse, start rejected because bank is full
//   timeout_err_o   : 1-cycle pulse, load aborted on stall
//
// Build option: CIM_LOADER_TIMEOUT_EN enables the stall counter and the
// TIMEOUT parameter; without it timeout_err_o is tied low and LOAD waits
// indefinitely for words.
// ---------------------------------------------------------------------------
module cim_weight_loader
    import cim_pkg::*;
#(
    parameter int DATA_W = CIM_DATA_W,
    parameter int ROWS   = CIM_ROWS
`ifdef CIM_LOADER_TIMEOUT_EN
    ,
    parameter int TIMEOUT = CIM_TIMEOUT
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              bank_sel_i,
    input  logic              s_valid_i,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              s_ready_o,
    input  logic [1:0]        release_i,
    output logic [DATA_W-1:0] d_o,
    output logic [ROWS-1:0]   wa_o,
    output logic              cima_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        bank_full_o,
    output logic              start_err_o,
    output logic              timeout_err_o
);

    loader_state_e     state_q;
    logic              target_q;
    logic [DATA_W-1:0] d_q;
    logic [ROWS-1:0]   wa_q;
    logic              cima_q;
    logic              done_q;
    logic              start_err_q;
    logic [1:0]        bank_full_q;
    logic [1:0]        bank_full_d;

    logic              beat;
    logic              accept_start;
    logic [ROWS-1:0]   row_onehot;
    logic              row_last;
    logic              stall_hit;

    assign beat         = s_valid_i && (state_q == LOAD);
    assign accept_start = (state_q == IDLE) && start_i && !bank_full_q[bank_sel_i];

    cim_row_onehot #(
        .ROWS (ROWS)
    ) u_row (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (accept_start),
        .inc_i    (beat),
        .onehot_o (row_onehot),
        .last_o   (row_last)
    );

`ifdef CIM_LOADER_TIMEOUT_EN
    // Counts beat-less LOAD cycles since the last beat (or since entering
    // LOAD). The abort is registered, so it is requested one cycle early:
    // the cycle in which timeout_err_o is high is itself the TIMEOUT-th
    // beat-less cycle, landing exactly TIMEOUT cycles after the last beat.
    localparam int STALL_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [STALL_W-1:0] stall_q;
    logic               timeout_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if ((state_q != LOAD) || beat) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end

    assign stall_hit = (state_q == LOAD) && !beat && (stall_q == STALL_W'(TIMEOUT - 2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= stall_hit;
        end
    end

    assign timeout_err_o = timeout_err_q;
`else
    assign stall_hit     = 1'b0;
    assign timeout_err_o = 1'b0;
`endif

    // Release clears first, then DONE sets, so a coincident set wins.
    always_comb begin
        bank_full_d = bank_full_q & ~release_i;
        if (state_q == DONE) begin
            bank_full_d[target_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            target_q    <= BANK0;
            d_q         <= '0;
            wa_q        <= '0;
            cima_q      <= 1'b0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
            bank_full_q <= 2'b00;
        end else begin
            // Pulse outputs and row select default low; D and cima hold.
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
            wa_q        <= '0;
            bank_full_q <= bank_full_d;

            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (bank_full_q[bank_sel_i]) begin
                            start_err_q <= 1'b1;
                        end else begin
                            target_q <= bank_sel_i;
                            state_q  <= LOAD;
                        end
                    end
                end

                LOAD: begin
                    if (beat) begin
                        d_q    <= s_data_i;
                        wa_q   <= row_onehot;
                        cima_q <= (target_q == BANK0);
                        if (row_last) begin
                            // done is raised together with the entry into DONE
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end else if (stall_hit) begin
                        state_q <= IDLE;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s_ready_o   = (state_q == LOAD);
    assign busy_o      = (state_q == LOAD) || (state_q == DONE);
    assign d_o         = d_q;
    assign wa_o        = wa_q;
    assign cima_o      = cima_q;
    assign done_o      = done_q;
    assign start_err_o = start_err_q;
    assign bank_full_o = bank_full_q;

endmodule

// File: tb/tb_cim_weight_loader.sv
// ---------------------------------------------------------------------------
// tb_cim_weight_loader
// Directed stimulus pushes expected array writes and done events into
// queues; a monitor pops and compares whenever the DUT drives a write
// (wa_o != 0) or a done pulse.
// ---------------------------------------------------------------------------
module tb_cim_weight_loader;
    import cim_pkg::*;

    localparam int DW = CIM_DATA_W;
    localparam int RW = CIM_ROWS;

    typedef struct packed {
        logic [RW-1:0] wa;
        logic [DW-1:0] d;
        logic          cima;
    } wr_t;

    logic          clk;
    logic          rst;
    logic          start_i;
    logic          bank_sel_i;
    logic          s_valid_i;
    logic [DW-1:0] s_data_i;
    logic          s_ready_o;
    logic [1:0]    release_i;
    logic [DW-1:0] d_o;
    logic [RW-1:0] wa_o;
    logic          cima_o;
    logic          busy_o;
    logic          done_o;
    logic [1:0]    bank_full_o;
    logic          start_err_o;
    logic          timeout_err_o;

    wr_t  exp_wr[$];
    logic exp_done[$];
    int   tests    = 0;
    int   fails    = 0;
    int   n_writes = 0;

    cim_weight_loader dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .bank_sel_i    (bank_sel_i),
        .s_valid_i     (s_valid_i),
        .s_data_i      (s_data_i),
        .s_ready_o     (s_ready_o),
        .release_i     (release_i),
        .d_o           (d_o),
        .wa_o          (wa_o),
        .cima_o        (cima_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .bank_full_o   (bank_full_o),
        .start_err_o   (start_err_o),
        .timeout_err_o (timeout_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW-1:0] onehot(input int r);
        logic [RW-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    task automatic expect_word(input logic bank, input int row, input logic [DW-1:0] data);
        wr_t w;
        w.wa   = onehot(row);
        w.d    = data;
        w.cima = (bank == 1'b0);
        exp_wr.push_back(w);
    endtask

    task automatic start_load(input logic bank);
        start_i    = 1'b1;
        bank_sel_i = bank;
        tick();
        start_i    = 1'b0;
    endtask

    // Full-rate load: start, 8 back-to-back words, release_i driven during DONE.
    task automatic full_load(input logic bank, input logic [DW-1:0] base, input logic [1:0] rel_at_done);
        exp_done.push_back(bank == 1'b0);
        start_load(bank);
        @(negedge clk);
        check("load_ready_busy", {busy_o, s_ready_o}, 2'b11);
        for (int r = 0; r < RW; r++) begin
            s_valid_i = 1'b1;
            s_data_i  = base + DW'(r);
            expect_word(bank, r, base + DW'(r));
            tick();
        end
        s_valid_i = 1'b0;
        release_i = rel_at_done;
        @(negedge clk);
        check("done_9_after_start", done_o, 1'b1);
        tick();
        release_i = 2'b00;
        @(negedge clk);
        check("done_single_pulse", {done_o, busy_o}, 2'b00);
        $display("[TB] load bank %0d base 0x%06h complete, bank_full=%b", bank, base, bank_full_o);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {d_o, wa_o, cima_o, s_ready_o, busy_o, done_o, bank_full_o,
                     start_err_o, timeout_err_o}, 64'd0);
    endtask

    // Monitor / scoreboard
    initial begin
        wr_t w;
        logic ec;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (wa_o != '0) begin
                    n_writes++;
                    if (exp_wr.size() == 0) begin
                        check("unexpected_write", {wa_o, d_o, cima_o}, 64'd0);
                    end else begin
                        w = exp_wr.pop_front();
                        check("array_write", {wa_o, d_o, cima_o}, w);
                        $display("[TB] write WA=0x%02h D=0x%06h cima=%0d", wa_o, d_o, cima_o);
                    end
                end
                if (done_o) begin
                    if (exp_done.size() == 0) begin
                        check("unexpected_done", done_o, 1'b0);
                    end else begin
                        ec = exp_done.pop_front();
                        check("done_bank_cima", cima_o, ec);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int row;
        int wr_base;
        int cyc;

        rst        = 1'b1;
        start_i    = 1'b0;
        bank_sel_i = 1'b0;
        s_valid_i  = 1'b0;
        s_data_i   = '0;
        release_i  = 2'b00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_values");
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Bank 0 full-rate load
        full_load(1'b0, 24'h000001, 2'b00);
        check("bank0_full", bank_full_o, 2'b01);

        // Bank 1 with bubbles; a start during LOAD (to full bank 0) is ignored
        exp_done.push_back(1'b0);
        wr_base = n_writes;
        start_load(1'b1);
        row = 0;
        for (int i = 0; i < 15; i++) begin
            s_valid_i  = (i % 2 == 0);
            start_i    = (i == 3);
            bank_sel_i = 1'b0;
            if (i % 2 == 0) begin
                s_data_i = 24'h0B0000 + DW'(i);
                expect_word(1'b1, row, 24'h0B0000 + DW'(i));
                row++;
            end else begin
                s_data_i = 24'hDEAD00 + DW'(i);
            end
            tick();
            start_i = 1'b0;
            @(negedge clk);
            check("bubble_wa", wa_o != '0, (i % 2 == 0));
            check("no_err_in_load", start_err_o, 1'b0);
        end
        s_valid_i = 1'b0;
        check("bubble_done", done_o, 1'b1);
        tick();
        @(negedge clk);
        check("bubble_write_count", n_writes - wr_base, 8);
        check("bank1_full", bank_full_o, 2'b11);

        // Reject start to full bank 0
        wr_base = n_writes;
        start_load(1'b0);
        @(negedge clk);
        check("start_err_pulse", {start_err_o, busy_o, s_ready_o}, 3'b100);
        s_valid_i = 1'b1;
        s_data_i  = 24'hBAD000;
        tick();
        @(negedge clk);
        check("start_err_clear", start_err_o, 1'b0);
        tick();
        s_valid_i = 1'b0;
        @(negedge clk);
        check("reject_no_writes", n_writes - wr_base, 0);
        $display("[TB] start to full bank 0 rejected");

        // Release bank 0, reload it
        release_i = 2'b01;
        tick();
        release_i = 2'b00;
        @(negedge clk);
        check("release0", bank_full_o, 2'b10);
        full_load(1'b0, 24'hA00000, 2'b00);
        check("reload_bank0", bank_full_o, 2'b11);

        // Set/release collision on bank 1
        release_i = 2'b10;
        tick();
        release_i = 2'b00;
        @(negedge clk);
        check("release1", bank_full_o, 2'b01);
        full_load(1'b1, 24'h5A5A50, 2'b10);
        check("collision_set_wins", bank_full_o, 2'b11);

        // Release both, then release of empty banks is a no-op
        release_i = 2'b11;
        tick();
        @(negedge clk);
        check("release_both", bank_full_o, 2'b00);
        tick();
        release_i = 2'b00;
        @(negedge clk);
        check("release_empty_noop", bank_full_o, 2'b00);

        // Reset mid-load
        start_load(1'b0);
        for (int r = 0; r < 3; r++) begin
            s_valid_i = 1'b1;
            s_data_i  = 24'h0C0000 + DW'(r);
            expect_word(1'b0, r, 24'h0C0000 + DW'(r));
            tick();
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_reset_midload");
        @(posedge clk);
        #1 rst = 1'b0;
        s_valid_i = 1'b0;
        tick();
        @(negedge clk);
        check_all_zero("after_reset_idle");
        $display("[TB] reset mid-load discarded partial load");

        full_load(1'b0, 24'h00C0DE, 2'b00);
        check("load_after_reset", bank_full_o, 2'b01);

`ifdef CIM_LOADER_TIMEOUT_EN
        start_load(1'b1);
        for (int r = 0; r < 3; r++) begin
            s_valid_i = 1'b1;
            s_data_i  = 24'h0E0000 + DW'(r);
            expect_word(1'b1, r, 24'h0E0000 + DW'(r));
            tick();
        end
        s_valid_i = 1'b0;
        cyc = 1;
        while (cyc < 200) begin
            @(negedge clk);
            if (timeout_err_o) break;
            tick();
            cyc++;
        end
        check("timeout_latency", cyc, 64);
        check("timeout_idle", {busy_o, done_o, s_ready_o}, 3'b000);
        check("timeout_bank_full", bank_full_o, 2'b01);
        tick();
        @(negedge clk);
        check("timeout_single_pulse", timeout_err_o, 1'b0);
        $display("[TB] timeout after %0d stall cycles", cyc);
`else
        cyc = 0;
        check("timeout_tied_low", timeout_err_o, 1'b0);
`endif

        repeat (3) tick();
        check("wr_queue_empty", exp_wr.size(), 0);
        check("done_queue_empty", exp_done.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
